// File: rtl/maxpool2d_stride_2.sv
`default_nettype none
// ============================================================================
// Module      : maxpool2d_stride_2
// Description : Streaming 2x2, stride-2 FP32 max-pool over a raster pixel
//               stream. Define MAXPOOL_RELU_EN to fuse ReLU into the output
//               register.
// Revision    : 1.0 - initial release
// ============================================================================
module maxpool2d_stride_2 #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_WIDTH  = 56,
    parameter int IMG_HEIGHT = 56
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  data_valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [31:0]           data_out,
    output logic                  valid_out_pixel,
    output logic                  done
);

    localparam int c_HALF_W = IMG_WIDTH / 2;
    localparam int c_OUT_N  = (IMG_WIDTH / 2) * (IMG_HEIGHT / 2);
    localparam int c_CW     = $clog2(IMG_WIDTH);
    localparam int c_RW     = $clog2(IMG_HEIGHT);
    localparam int c_HW     = (c_HALF_W > 1) ? $clog2(c_HALF_W) : 1;
    localparam int c_OW     = (c_OUT_N > 1) ? $clog2(c_OUT_N) : 1;

    localparam logic [c_CW-1:0] c_COL_LAST = c_CW'(IMG_WIDTH - 1);
    localparam logic [c_RW-1:0] c_ROW_LAST = c_RW'(IMG_HEIGHT - 1);
    localparam logic [c_OW-1:0] c_OUT_LAST = c_OW'(c_OUT_N - 1);

    logic [c_CW-1:0]       r_col;
    logic [c_RW-1:0]       r_row;
    logic [c_OW-1:0]       r_out_cnt;
    logic [DATA_WIDTH-1:0] r_hold;
    logic [DATA_WIDTH-1:0] r_rowbuf [c_HALF_W];
    logic [31:0]           r_data_out;
    logic                  r_valid;
    logic                  r_done;

    logic [c_HW-1:0]       w_idx;
    logic [DATA_WIDTH-1:0] w_hmax;
    logic [DATA_WIDTH-1:0] w_rb_rd;
    logic [DATA_WIDTH-1:0] w_pool;
    logic [31:0]           w_result;
    logic                  w_fire;
    logic                  w_rb_we;
    logic                  w_last;

    // Sign-magnitude ordering; equal values (and +0 vs -0) keep operand a.
    function automatic logic f_keep_first(input logic [DATA_WIDTH-1:0] a,
                                          input logic [DATA_WIDTH-1:0] b);
        logic r;
        if ((a[DATA_WIDTH-2:0] == '0) && (b[DATA_WIDTH-2:0] == '0))
            r = 1'b1;
        else if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1])
            r = ~a[DATA_WIDTH-1];
        else if (!a[DATA_WIDTH-1])
            r = (a[DATA_WIDTH-2:0] >= b[DATA_WIDTH-2:0]);
        else
            r = (a[DATA_WIDTH-2:0] <= b[DATA_WIDTH-2:0]);
        return r;
    endfunction

    assign w_idx   = c_HW'(r_col >> 1);
    assign w_rb_rd = r_rowbuf[w_idx];
    assign w_hmax  = f_keep_first(r_hold, data_in) ? r_hold : data_in;
    assign w_pool  = f_keep_first(w_rb_rd, w_hmax) ? w_rb_rd : w_hmax;
    assign w_fire  = data_valid_in & r_col[0] & r_row[0];
    assign w_rb_we = data_valid_in & r_col[0] & ~r_row[0];
    assign w_last  = (r_out_cnt == c_OUT_LAST);

`ifdef MAXPOOL_RELU_EN
    assign w_result = w_pool[DATA_WIDTH-1] ? 32'h0000_0000 : w_pool;
`else
    assign w_result = w_pool;
`endif

    // Raster position and horizontal-pair hold register; idle cycles freeze.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_col  <= '0;
            r_row  <= '0;
            r_hold <= '0;
        end else if (data_valid_in) begin
            if (r_col == c_COL_LAST) begin
                r_col <= '0;
                r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + c_RW'(1);
            end else begin
                r_col <= r_col + c_CW'(1);
            end
            if (!r_col[0])
                r_hold <= data_in;
        end
    end

    // Even rows deposit their horizontal maxima here; odd rows read them back.
    always_ff @(posedge clk) begin
        if (w_rb_we)
            r_rowbuf[w_idx] <= w_hmax;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_data_out <= '0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_out_cnt  <= '0;
        end else begin
            r_valid <= w_fire;
            r_done  <= w_fire & w_last;
            if (w_fire) begin
                r_data_out <= w_result;
                r_out_cnt  <= w_last ? '0 : r_out_cnt + c_OW'(1);
            end
        end
    end

    assign data_out        = r_data_out;
    assign valid_out_pixel = r_valid;
    assign done            = r_done;

endmodule
`default_nettype wire
